dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive locked grants before forced hand-over (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0/req1  input  1 each  access request; port 0 = CPU, port 1 = auxiliary (loader/DMA).
REQ-005 lock0/lock1  input  1 each  requester asks to keep ownership on the next cycle (burst).
REQ-006 we0/we1  input  1 each  write enable of requester.
REQ-007 addr0/addr1  input  32 each  byte address.
REQ-008 wd0/wd1  input  32 each  write data.
REQ-009 wm0/wm1  input  4 each  byte write mask.
REQ-010 gnt0/gnt1  output  1 each  access performed this cycle; combinational, one-hot or zero.
REQ-011 rdata0/rdata1  output  32 each  registered read data.
REQ-012 rvalid0/rvalid1  output  1 each  rdataN valid; one-cycle pulse.
REQ-013 m_we  output  1  memory write enable.
REQ-014 m_addr  output  32  memory address.
REQ-015 m_wd  output  32  memory write data.
REQ-016 m_wm  output  4  memory write mask.
REQ-017 m_rd  input  32  memory read data, combinational from m_addr.

Function
REQ-018 FSM states IDLE, OWN0, OWN1; state = port that won the previous cycle while holding lock.
REQ-019 IDLE: winner chosen by priority rule (REQ-030/031) among asserted reqN; no req -> no grant, stay IDLE.
REQ-020 OWNn with reqn=1: grant n again, unless hold counter = MAX_HOLD and the other port requests -> grant the other port.
REQ-021 OWNn with reqn=0: ownership released same cycle; arbitrate as IDLE.
REQ-022 Next state = OWNn if granted port n has lockn=1 and was not force-released, else IDLE.
REQ-023 Hold counter: 8 bits; reset to 1 on each new owner; +1 per consecutive granted cycle of same owner; saturates at MAX_HOLD.
REQ-024 Forced release: port loses ownership for at least one cycle; previous owner's lock ignored that cycle.
REQ-025 m_* driven from granted port; no grant -> m_we=0, m_addr=0, m_wd=0, m_wm=0.
REQ-026 m_we = weN of granted port; write completes at the grant clock edge.
REQ-027 Granted read (weN=0): m_rd captured into rdataN at the grant edge; rvalidN=1 the following cycle only.
REQ-028 Granted write: no rvalid; rdataN holds previous value.
REQ-029 Non-granted requester SHALL hold req and payload stable until gnt; arbiter does not buffer.

Configuration
REQ-030 Macro DMEM_ARBITER_RR_EN defined: round-robin in IDLE; on simultaneous req, port not granted most recently wins; last-grant pointer resets to port 1 (port 0 wins first tie).
REQ-031 Macro undefined: fixed priority, port 0 wins every IDLE tie; MAX_HOLD forced release still applies.

Reset
REQ-032 reset low: state IDLE, hold counter 0, last-grant pointer port 1, rdata0/1=0, rvalid0/1=0, immediately, independent of clk.
REQ-033 Reset asserted mid-burst: in-flight rvalid is dropped; no write issued while reset low (gnt forced 0).
REQ-034 Release of reset takes effect at first rising edge after reset goes high.

Verification
REQ-035 req0=1 we0=0 addr0=0x40, memory[0x40]=0x12345678 -> gnt0 same cycle, next cycle rvalid0=1 rdata0=0x12345678, rvalid1=0.
REQ-036 req0=req1=1 both unlocked, 4 cycles, RR_EN defined -> grants 0,1,0,1; RR_EN undefined -> 0,0,0,0.
REQ-037 req1 lock1=1 continuous writes, req0 raised on cycle 2, MAX_HOLD=8 -> gnt1 for cycles 1..8, gnt0 at cycle 9.
REQ-038 Simultaneous writes addr0=0x10 wd0=0xAAAA0000 and addr1=0x10 wd1=0x0000BBBB wm1=4'b0011 -> memory reflects winning port first, loser's write next cycle; final 0xAAAABBBB with RR_EN (port 0 first).
REQ-039 reset low during locked read burst -> rvalid0/1=0 and gnt=0 same cycle without clk edge; after release, idle arbitration restarts with port 0 priority.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU / auxiliary) arbiter in front of a single-port
// data memory. Supports locked bursts with a bounded hold time, and
// registered read-data return per port.
// Optional feature: define DMEM_ARBITER_RR_EN for round-robin tie-breaking
// in IDLE; otherwise port 0 has fixed priority.
//
// state | meaning
// IDLE  | nobody owns the memory; arbitrate among requests
// OWN0  | port 0 won last cycle with lock0 set; keeps the memory if requesting
// OWN1  | port 1 won last cycle with lock1 set; keeps the memory if requesting

module dmem_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        lock0_i,
  input  logic        lock1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wd0_i,
  input  logic [31:0] wd1_i,
  input  logic [3:0]  wm0_i,
  input  logic [3:0]  wm1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic        rvalid0_o,
  output logic        rvalid1_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wd_o,
  output logic [3:0]  m_wm_o,
  input  logic [31:0] m_rd_i
);

  localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

`ifdef DMEM_ARBITER_RR_EN
  localparam logic RrEn = 1'b1;
`else
  localparam logic RrEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        last_q, last_d;        // port granted most recently
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic        grant0, grant1;
  logic        idle_pick1;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Arbitration and next state; grants are suppressed while reset is low
  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    state_d = IDLE;
    if (req0_i && req1_i) idle_pick1 = RrEn & ~last_q;
    else                  idle_pick1 = req1_i;
    unique case (state_q)
      OWN0: begin
        if (req0_i) begin
          if (hold_q == MaxHold && req1_i) grant1 = 1'b1;
          else                             grant0 = 1'b1;
        end else begin
          grant1 = idle_pick1;
          grant0 = (req0_i | req1_i) & ~idle_pick1;
        end
      end
      OWN1: begin
        if (req1_i) begin
          if (hold_q == MaxHold && req0_i) grant0 = 1'b1;
          else                             grant1 = 1'b1;
        end else begin
          grant1 = idle_pick1;
          grant0 = (req0_i | req1_i) & ~idle_pick1;
        end
      end
      default: begin
        grant1 = idle_pick1;
        grant0 = (req0_i | req1_i) & ~idle_pick1;
      end
    endcase
    grant0 = grant0 & rst_ni;
    grant1 = grant1 & rst_ni;
    // A force-released owner is never the granted port, so its lock drops out
    if (grant0 && lock0_i)      state_d = OWN0;
    else if (grant1 && lock1_i) state_d = OWN1;
  end

  // Outputs: grants and memory-side mux from the granted port
  always_comb begin
    gnt0_o   = grant0;
    gnt1_o   = grant1;
    m_we_o   = 1'b0;
    m_addr_o = 32'h0;
    m_wd_o   = 32'h0;
    m_wm_o   = 4'h0;
    if (grant0) begin
      m_we_o   = we0_i;
      m_addr_o = addr0_i;
      m_wd_o   = wd0_i;
      m_wm_o   = wm0_i;
    end else if (grant1) begin
      m_we_o   = we1_i;
      m_addr_o = addr1_i;
      m_wd_o   = wd1_i;
      m_wm_o   = wm1_i;
    end
  end

  // Hold counter, last-grant pointer and read-return next values
  always_comb begin
    hold_d = 8'd0;
    if ((grant0 && state_q == OWN0) || (grant1 && state_q == OWN1))
      hold_d = (hold_q >= MaxHold) ? MaxHold : hold_q + 8'd1;
    else if (grant0 || grant1)
      hold_d = 8'd1;
    last_d    = grant0 ? 1'b0 : (grant1 ? 1'b1 : last_q);
    rvalid0_d = grant0 & ~we0_i;
    rvalid1_d = grant1 & ~we1_i;
    rdata0_d  = rvalid0_d ? m_rd_i : rdata0_q;
    rdata1_d  = rvalid1_d ? m_rd_i : rdata1_q;
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q    <= 8'd0;
      last_q    <= 1'b1;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      last_q    <= last_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;
  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: table-driven vectors plus hand-written
// sequences for hold-limit, simultaneous writes and mid-burst reset.
// Read returns are checked through a scoreboard queue.

module tb_dmem_arbiter;

`ifdef DMEM_ARBITER_RR_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic        clk, rst_n;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic [3:0]  wm0, wm1;
  logic        gnt0, gnt1, rvalid0, rvalid1, m_we;
  logic [31:0] rdata0, rdata1, m_addr, m_wd, m_rd;
  logic [3:0]  m_wm;
  logic [31:0] mem [256];

  typedef struct {
    logic        r0, r1, l0, l1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  m0, m1;
    logic        g0, g1;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } sb_t;

  sb_t  sbq[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  dmem_arbiter #(.MAX_HOLD(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .req1_i(req1), .lock0_i(lock0), .lock1_i(lock1),
    .we0_i(we0), .we1_i(we1), .addr0_i(addr0), .addr1_i(addr1),
    .wd0_i(wd0), .wd1_i(wd1), .wm0_i(wm0), .wm1_i(wm1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .m_we_o(m_we), .m_addr_o(m_addr), .m_wd_o(m_wd), .m_wm_o(m_wm),
    .m_rd_i(m_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, byte-masked write at the clock edge
  assign m_rd = mem[m_addr[9:2]];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 | i;
      mem[16] <= 32'h12345678;
    end else if (m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_wm[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wd[8*b +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0, r1, l0, l1, w0, w1,
                              input logic [31:0] a0, a1, input logic g0, g1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1;
    v.d0 = 32'hD0D00000 ^ a0; v.d1 = 32'hD1D10000 ^ a1;
    v.m0 = 4'hF; v.m1 = 4'hF;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req0 = v.r0; req1 = v.r1; lock0 = v.l0; lock1 = v.l1;
    we0 = v.w0; we1 = v.w1; addr0 = v.a0; addr1 = v.a1;
    wd0 = v.d0; wd1 = v.d1; wm0 = v.m0; wm1 = v.m1;
  endtask

  // One cycle: drive, check grant and memory bus, then check read return
  task automatic step(input vec_t v, input string tag);
    sb_t         e;
    logic        ew;
    logic [31:0] ea, ed;
    logic [3:0]  em;
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, ".gnt"}, {30'd0, gnt1, gnt0}, {30'd0, v.g1, v.g0});
    ew = 1'b0; ea = 32'h0; ed = 32'h0; em = 4'h0;
    if (v.g0) begin ew = v.w0; ea = v.a0; ed = v.d0; em = v.m0; end
    else if (v.g1) begin ew = v.w1; ea = v.a1; ed = v.d1; em = v.m1; end
    chk({tag, ".m_we_wm"}, {27'd0, m_wm, m_we}, {27'd0, em, ew});
    chk({tag, ".m_addr"}, m_addr, ea);
    if (ew) chk({tag, ".m_wd"}, m_wd, ed);
    if ((v.g0 || v.g1) && !ew) begin
      e.port = v.g1;
      e.data = mem[ea[9:2]];
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, ".rvalid"}, {30'd0, rvalid1, rvalid0}, e.port ? 32'd2 : 32'd1);
      chk({tag, ".rdata"}, e.port ? rdata1 : rdata0, e.data);
    end else begin
      chk({tag, ".rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with a write request present: nothing may be granted
    rst_n = 1'b0;
    v = mk(1, 1, 0, 0, 1, 1, 32'h20, 32'h24, 0, 0);
    drive(v);
    #7;
    chk("rst.gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst.m_we", {31'd0, m_we}, 32'd0);
    chk("rst.rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("rst.rdata0", rdata0, 32'h0);
    chk("rst.rdata1", rdata1, 32'h0);
    drive(idle);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h40, 32'h0, 1, 0));
    tbl.push_back(idle);
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0, 32'h4C, 0, 1));
    for (int i = 0; i < 4; i++) begin
      logic p1;
      p1 = RR & (i % 2 == 1);
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h44, 32'h48, ~p1, p1));
    end
    v = mk(0, 1, 0, 0, 0, 1, 32'h0, 32'h80, 0, 1);
    v.m1 = 4'b0101;
    tbl.push_back(v);
    tbl.push_back(idle);
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("tbl%0d", i));

    // Simultaneous writes to one word: winner first, loser next cycle
    v = mk(1, 1, 0, 0, 1, 1, 32'h10, 32'h10, 1, 0);
    v.d0 = 32'hAAAA0000; v.d1 = 32'h0000BBBB; v.m1 = 4'b0011;
    step(v, "wr.a");
    v.r0 = 1'b0; v.g0 = 1'b0; v.g1 = 1'b1;
    step(v, "wr.b");
    step(idle, "wr.c");
    chk("wr.mem", mem[4], 32'hAAAABBBB);

    // Locked write burst on port 1 hits the hold limit
    for (int c = 1; c <= 10; c++) begin
      v = mk(c >= 2 && c <= 9, 1, 0, 1, 0, 1, 32'h60, 32'h100 + 4 * c,
             c == 9, c <= 8 || c == 10);
      step(v, $sformatf("hold%0d", c));
    end
    step(idle, "hold.end");

    // Reset in the middle of a locked read burst
    step(mk(1, 0, 1, 0, 0, 0, 32'h40, 32'h0, 1, 0), "rb.1");
    step(mk(1, 0, 1, 0, 0, 0, 32'h44, 32'h0, 1, 0), "rb.2");
    #1 rst_n = 1'b0;
    #1;
    chk("rb.gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("rb.rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("rb.rdata0", rdata0, 32'h0);
    chk("rb.m_addr", m_addr, 32'h0);
    sbq.delete();
    drive(idle);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(1, 1, 0, 0, 0, 0, 32'h48, 32'h4C, 1, 0), "rb.arb1");
    step(mk(1, 1, 0, 0, 0, 0, 32'h48, 32'h4C, ~RR, RR), "rb.arb2");
    step(idle, "rb.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
